// File: rtl/acap_key_streamer_pkg.sv
// acap_key_streamer_pkg: shared FSM state type and index-width helper for the key streamer
package acap_key_streamer_pkg;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/acap_key_streamer_fifo.sv
// acap_key_streamer_fifo: synchronous FIFO with occupancy count for returned key words
module acap_key_streamer_fifo
   import acap_key_streamer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);
   localparam int PW = idx_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wp, r_rp;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   assign w_pop = pop && r_count != '0;
   assign dout  = r_mem[r_rp];
   assign count = r_count;
   assign empty = r_count == '0;
   always_ff @(posedge clk)
      if (push) r_mem[r_wp] <= din;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         r_wp    <= r_wp + PW'(push);
         r_rp    <= r_rp + PW'(w_pop);
         r_count <= r_count + CW'(push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/acap_key_streamer.sv
// acap_key_streamer: splits LWE coefficients into digits, issues key reads under a credit
// limit, and streams the returned key words with their (i, j) tags over valid/ready.
module acap_key_streamer
   import acap_key_streamer_pkg::*;
#(
   parameter int LWE_SIZE   = 500,
   parameter int D_R        = 3,
   parameter int B_R_BITS   = 5,
   parameter int KEY_WIDTH  = 1024,
   parameter int READ_LAT   = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = $clog2(LWE_SIZE * D_R * (1 << B_R_BITS)),
   parameter int LI_W       = idx_w(LWE_SIZE),
   parameter int DJ_W       = idx_w(D_R)
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      skip_zero,
   input  logic                      a_valid,
   input  logic [D_R*B_R_BITS-1:0]   a_data,
   output logic                      a_ready,
   output logic                      mem_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [KEY_WIDTH-1:0]      mem_rdata,
   output logic                      key_valid,
   input  logic                      key_ready,
   output logic [KEY_WIDTH-1:0]      key_data,
   output logic [LI_W-1:0]           key_lwe_idx,
   output logic [DJ_W-1:0]           key_digit_idx,
   output logic                      busy,
   output logic                      done
);
   localparam int IDX_W = ADDR_W - B_R_BITS;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SB_W  = LI_W + DJ_W;
   localparam int FW    = KEY_WIDTH + SB_W;
   localparam int CW    = D_R * B_R_BITS;
   state_t              r_state;
   logic                r_held, r_skip, r_busy, r_done, r_mem_en;
   logic [CW-1:0]       r_coef;
   logic [LI_W-1:0]     r_i;
   logic [DJ_W-1:0]     r_j;
   logic [IDX_W-1:0]    r_base;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [SB_W-1:0]     r_sb;
   logic [CNT_W-1:0]    r_inflight;
   logic [READ_LAT-1:0] r_pv;
   logic [SB_W-1:0]     r_psb [READ_LAT];
   logic [CW-1:0]       w_coef;
   logic [B_R_BITS-1:0] w_digit;
   logic [IDX_W-1:0]    w_idx;
   logic [CNT_W-1:0]    w_count;
   logic [FW-1:0]       w_head;
   logic w_slot, w_zero, w_credit, w_adv, w_rd, w_last_j, w_last_i;
   logic w_drained, w_push, w_pop, w_empty;
   // digit 0 is worked on in the accept cycle, straight from a_data
   assign w_coef    = r_held ? r_coef : a_data;
   assign w_digit   = w_coef[B_R_BITS-1:0];
   assign w_slot    = r_state == S_FETCH && (r_held || a_valid);
   assign w_zero    = r_skip && w_digit == '0;
   assign w_credit  = {1'b0, w_count} + {1'b0, r_inflight} < (CNT_W+1)'(FIFO_DEPTH);
   assign w_adv     = w_slot && (w_zero || w_credit);
   assign w_rd      = w_slot && !w_zero && w_credit;
   assign w_last_j  = r_j == DJ_W'(D_R - 1);
   assign w_last_i  = r_i == LI_W'(LWE_SIZE - 1);
   assign w_idx     = r_base + IDX_W'(r_j);
   assign w_drained = r_inflight == '0 && w_empty;
   assign w_push    = r_pv[READ_LAT-1];
   assign w_pop     = key_valid && key_ready;
   assign a_ready   = r_state == S_FETCH && !r_held;
   assign mem_en    = r_mem_en;
   assign mem_addr  = r_mem_addr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign key_valid = !w_empty;
   assign {key_lwe_idx, key_digit_idx, key_data} = w_empty ? '0 : w_head;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_held     <= 1'b0;
         r_skip     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mem_en   <= 1'b0;
         r_coef     <= '0;
         r_i        <= '0;
         r_j        <= '0;
         r_base     <= '0;
         r_mem_addr <= '0;
         r_sb       <= '0;
      end else begin
         r_mem_en <= w_rd;
         r_done   <= 1'b0;
         if (w_rd) begin
            r_mem_addr <= {w_idx, w_digit};
            r_sb       <= {r_i, r_j};
         end
         case (r_state)
            S_IDLE: if (start) begin
               r_state <= S_FETCH;
               r_busy  <= 1'b1;
               r_skip  <= skip_zero;
               r_held  <= 1'b0;
               r_i     <= '0;
               r_j     <= '0;
               r_base  <= '0;
            end
            S_FETCH: if (w_slot) begin
               r_coef <= w_adv ? w_coef >> B_R_BITS : w_coef;
               r_held <= !(w_adv && w_last_j);
               if (w_adv) begin
                  r_j <= w_last_j ? '0 : r_j + DJ_W'(1);
                  if (w_last_j && w_last_i) begin
                     r_state <= w_drained && !w_rd ? S_DONE : S_DRAIN;
                     r_done  <= w_drained && !w_rd;
                  end else if (w_last_j) begin
                     r_i    <= r_i + LI_W'(1);
                     r_base <= r_base + IDX_W'(D_R);
                  end
               end
            end
            S_DRAIN: if (w_drained) begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
   // in-flight reads hold FIFO credit until their data lands
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight <= '0;
         r_pv       <= '0;
      end else begin
         r_inflight <= r_inflight + CNT_W'(w_rd) - CNT_W'(w_push);
         r_pv[0]    <= r_mem_en;
         for (int k = 1; k < READ_LAT; k++) r_pv[k] <= r_pv[k-1];
      end
   end
   always_ff @(posedge clk) begin
      r_psb[0] <= r_sb;
      for (int k = 1; k < READ_LAT; k++) r_psb[k] <= r_psb[k-1];
   end
   acap_key_streamer_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   ({r_psb[READ_LAT-1], mem_rdata}),
      .pop   (w_pop),
      .dout  (w_head),
      .count (w_count),
      .empty (w_empty)
   );
endmodule

// File: tb/tb_acap_key_streamer.sv
// tb_acap_key_streamer: randomized bench; instance 0 uses READ_LAT=2, instance 1 READ_LAT=5,
// both with LWE_SIZE=4 and a word-list reference model built from the digit/address rules.
module tb_acap_key_streamer;
   logic        clk, reset;
   logic        start [2], skip_zero [2], a_valid [2], key_ready [2];
   logic        a_ready [2], mem_en [2], key_valid [2], busy [2], done [2];
   logic [14:0] a_data [2];
   logic [8:0]  mem_addr [2];
   logic [31:0] mem_rdata [2], key_data [2];
   logic [1:0]  key_lwe_idx [2], key_digit_idx [2];
   int kr_mode [2], en_cnt [2], pop_cnt [2], done_cnt [2], done_lat [2], max_o [2], gaps [2], qn [2];
   int n_vec, n_err, pcnt, dc;
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) pcnt++;
   function automatic logic [31:0] kf(input logic [8:0] a);
      return {a, ~a, a, a[4:0]};
   endfunction
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic start_pass(input int k, input logic s);
      skip_zero[k] = s;
      start[k] = 1;
      cyc(1);
      start[k] = 0;
   endtask
   task automatic feed(input int k, input logic [14:0] v);
      logic got;
      got = 0;
      a_valid[k] = 1;
      a_data[k] = v;
      for (int t = 0; t < 300 && !got; t++) begin
         @(negedge clk);
         got = a_ready[k];
         cyc(1);
      end
      a_valid[k] = 0;
      if (!got) chk("a_accept_timeout", 0, 1);
   endtask
   task automatic wait_done(input int k, input int d0);
      int t;
      t = 0;
      while (done_cnt[k] == d0 && t < 3000) begin
         cyc(1);
         t++;
      end
      if (done_cnt[k] == d0) chk("done_timeout", 0, 1);
   endtask
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int RL = g ? 5 : 2;
      logic [31:0] rp [RL];
      logic [35:0] q [$];
      logic [35:0] e;
      logic [4:0]  d;
      logic        sm;
      int          im, lastp, outst, acc_edge;
      acap_key_streamer #(.LWE_SIZE(4), .D_R(3), .B_R_BITS(5), .KEY_WIDTH(32),
                          .READ_LAT(RL), .FIFO_DEPTH(8)) dut (
         .clk           (clk),
         .reset         (reset),
         .start         (start[g]),
         .skip_zero     (skip_zero[g]),
         .a_valid       (a_valid[g]),
         .a_data        (a_data[g]),
         .a_ready       (a_ready[g]),
         .mem_en        (mem_en[g]),
         .mem_addr      (mem_addr[g]),
         .mem_rdata     (mem_rdata[g]),
         .key_valid     (key_valid[g]),
         .key_ready     (key_ready[g]),
         .key_data      (key_data[g]),
         .key_lwe_idx   (key_lwe_idx[g]),
         .key_digit_idx (key_digit_idx[g]),
         .busy          (busy[g]),
         .done          (done[g])
      );
      always @(posedge clk) begin
         rp[0] <= mem_en[g] ? kf(mem_addr[g]) : 32'hdeadbeef;
         for (int s = 1; s < RL; s++) rp[s] <= rp[s-1];
      end
      assign mem_rdata[g] = rp[RL-1];
      initial forever begin
         @(posedge clk);
         #1;
         key_ready[g] = kr_mode[g] == 2 ? 1'($urandom_range(0, 1)) : kr_mode[g] == 1;
      end
      always @(negedge clk) begin
         if (reset) begin
            q.delete();
            outst = 0;
         end else begin
            if (start[g] && !busy[g]) begin
               im = 0;
               sm = skip_zero[g];
               en_cnt[g] = 0;
               pop_cnt[g] = 0;
               gaps[g] = 0;
            end
            if (a_valid[g] && a_ready[g]) begin
               for (int j = 0; j < 3; j++) begin
                  d = a_data[g][j*5 +: 5];
                  if (!(sm && d == 0)) q.push_back({2'(im), 2'(j), kf(9'((im*3 + j)*32 + int'(d)))});
               end
               im++;
               acc_edge = pcnt + 1;
            end
            if (mem_en[g]) begin
               en_cnt[g]++;
               outst++;
            end
            if (key_valid[g] && key_ready[g]) begin
               if (pop_cnt[g] > 0 && pcnt != lastp + 1) gaps[g]++;
               lastp = pcnt;
               pop_cnt[g]++;
               outst--;
               if (q.size() == 0) chk("extra_word", 1, 0);
               else begin
                  e = q.pop_front();
                  chk("key_data", key_data[g], e[31:0]);
                  chk("key_lwe_idx", key_lwe_idx[g], e[35:34]);
                  chk("key_digit_idx", key_digit_idx[g], e[33:32]);
               end
            end
            if (outst > max_o[g]) max_o[g] = outst;
            if (done[g]) begin
               done_cnt[g]++;
               done_lat[g] = pcnt - acc_edge;
            end
         end
         qn[g] = q.size();
      end
   end
   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1;
      for (int k = 0; k < 2; k++) begin
         start[k] = 0;
         skip_zero[k] = 0;
         a_valid[k] = 0;
         a_data[k] = 0;
         kr_mode[k] = 1;
      end
      cyc(3);
      chk("rst_busy", busy[0], 0);
      chk("rst_a_ready", a_ready[0], 0);
      chk("rst_mem_en", mem_en[0], 0);
      chk("rst_key_valid", key_valid[0], 0);
      chk("rst_key_data", key_data[0], 0);
      chk("rst_done", done[0], 0);
      reset = 0;
      cyc(2);
      // full-rate pass with random coefficients
      dc = done_cnt[0];
      start_pass(0, 0);
      for (int c = 0; c < 4; c++) feed(0, 15'($urandom));
      wait_done(0, dc);
      chk("t1_busy_low", busy[0], 0);
      cyc(5);
      chk("t1_words", pop_cnt[0], 12);
      chk("t1_leftover", qn[0], 0);
      chk("t1_done_once", done_cnt[0], dc + 1);
      // random back-pressure and random coefficient gaps
      kr_mode[0] = 2;
      dc = done_cnt[0];
      start_pass(0, 0);
      for (int c = 0; c < 4; c++) begin
         feed(0, 15'($urandom));
         cyc($urandom_range(0, 2));
      end
      wait_done(0, dc);
      cyc(3);
      chk("t2_words", pop_cnt[0], 12);
      chk("t2_leftover", qn[0], 0);
      chk("t2_credit", max_o[0] <= 8, 1);
      kr_mode[0] = 1;
      // skip mode, only the middle digit is nonzero
      dc = done_cnt[0];
      start_pass(0, 1);
      for (int c = 0; c < 4; c++) feed(0, 15'h00e0);
      wait_done(0, dc);
      cyc(3);
      chk("t3_words", pop_cnt[0], 4);
      chk("t3_reads", en_cnt[0], 4);
      chk("t3_leftover", qn[0], 0);
      // skip mode, all digits zero
      dc = done_cnt[0];
      start_pass(0, 1);
      for (int c = 0; c < 4; c++) feed(0, 15'h0000);
      wait_done(0, dc);
      chk("t4_busy_low", busy[0], 0);
      cyc(3);
      chk("t4_reads", en_cnt[0], 0);
      chk("t4_words", pop_cnt[0], 0);
      chk("t4_done_once", done_cnt[0], dc + 1);
      chk("t4_done_latency", done_lat[0], 2);
      // reset in the middle of FETCH, then a clean pass
      dc = done_cnt[0];
      start_pass(0, 0);
      feed(0, 15'($urandom));
      feed(0, 15'($urandom));
      reset = 1;
      cyc(2);
      chk("t6_rst_busy", busy[0], 0);
      chk("t6_rst_key_valid", key_valid[0], 0);
      chk("t6_rst_a_ready", a_ready[0], 0);
      reset = 0;
      cyc(4);
      chk("t6_no_done", done_cnt[0], dc);
      start_pass(0, 0);
      for (int c = 0; c < 4; c++) feed(0, 15'($urandom));
      wait_done(0, dc);
      cyc(3);
      chk("t6_words", pop_cnt[0], 12);
      chk("t6_leftover", qn[0], 0);
      chk("t6_done_once", done_cnt[0], dc + 1);
      // long read latency with the consumer stalled, then released
      kr_mode[1] = 0;
      dc = done_cnt[1];
      start_pass(1, 0);
      fork
         for (int c = 0; c < 4; c++) feed(1, 15'($urandom));
      join_none
      cyc(20);
      chk("t5_reads_at_stall", en_cnt[1], 8);
      chk("t5_no_pops", pop_cnt[1], 0);
      kr_mode[1] = 1;
      wait_done(1, dc);
      wait fork;
      cyc(3);
      chk("t5_words", pop_cnt[1], 12);
      chk("t5_gaps", gaps[1], 0);
      chk("t5_leftover", qn[1], 0);
      chk("t5_credit", max_o[1] <= 8, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
